// File: rtl/capture_sequencer.sv
// capture_sequencer: multi-channel trigger-capture engine.
// Samples are written continuously into a CAPTURE_LENGTH-deep ring. PRETRIGGER_LENGTH
// samples of history are kept before the trigger. After the trigger, the post-trigger
// window is filled. The whole window is then streamed out oldest-first over ready/valid.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   arm                  pulse; starts a capture from IDLE
//   auto_rearm           level; 1 returns to FILL after readout, 0 to IDLE
//   trigger              pulse; honoured only while ARMED
//   axiiv / axiid        input sample valid / packed sample word (no backpressure)
//   axior                downstream ready
//   axiov/axiod/axiol    output valid / sample word / last beat of window
//   busy                 high whenever not IDLE
//   done                 one-cycle pulse after the final beat is accepted
//   dropped              sticky flag: an input sample was discarded
module capture_sequencer #(
  parameter int unsigned SAMPLE_DATA_WIDTH = 8,
  parameter int unsigned NUM_CHANNELS      = 1,
  parameter int unsigned CAPTURE_LENGTH    = 1000,
  parameter int unsigned PRETRIGGER_LENGTH = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      arm,
  input  logic                                      auto_rearm,
  input  logic                                      trigger,
  input  logic                                      axiiv,
  input  logic [SAMPLE_DATA_WIDTH*NUM_CHANNELS-1:0] axiid,
  input  logic                                      axior,
  output logic                                      axiov,
  output logic [SAMPLE_DATA_WIDTH*NUM_CHANNELS-1:0] axiod,
  output logic                                      axiol,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      dropped
);

  localparam int unsigned W  = SAMPLE_DATA_WIDTH * NUM_CHANNELS;
  localparam int unsigned AW = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(CAPTURE_LENGTH - 1);
  localparam logic [AW-1:0] PRE_M1   = AW'((PRETRIGGER_LENGTH > 0) ? PRETRIGGER_LENGTH - 1 : 0);
  // The post count is held as "remaining minus one" so that CAPTURE_LENGTH itself
  // (PRETRIGGER_LENGTH = 0) still fits in AW bits.
  localparam logic [AW-1:0] POST_M1  = AW'(CAPTURE_LENGTH - PRETRIGGER_LENGTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_READOUT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wp_q, wp_d;
  logic [AW-1:0]   fill_q, fill_d;
  logic [AW-1:0]   post_q, post_d;
  logic [AW-1:0]   rp_q, rp_d;
  logic [AW-1:0]   rcnt_q, rcnt_d;
  logic            axiov_q, axiov_d;
  logic            axiol_q, axiol_d;
  logic [W-1:0]    axiod_q;
  logic            done_q, done_d;
  logic            dropped_q, dropped_d;
  logic            we, load, fill_entry, advance;

  logic [W-1:0]    mem [CAPTURE_LENGTH];

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    fill_d     = fill_q;
    post_d     = post_q;
    rp_d       = rp_q;
    rcnt_d     = rcnt_q;
    axiov_d    = axiov_q;
    axiol_d    = axiol_q;
    done_d     = 1'b0;
    we         = 1'b0;
    load       = 1'b0;
    fill_entry = 1'b0;
    // The output register may take a new beat when it is empty or being drained.
    advance    = !axiov_q || axior;

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          state_d    = S_FILL;
          fill_entry = 1'b1;
        end
      end
      S_FILL: begin
        we = axiiv;
        if (PRETRIGGER_LENGTH == 0) begin
          state_d = S_ARMED;
        end else if (axiiv) begin
          fill_d = fill_q + 1'b1;
          if (fill_q == PRE_M1) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        we = axiiv;
        if (trigger) begin
          if (!axiiv) begin
            state_d = S_POST;
            post_d  = POST_M1;
          end else if (POST_M1 == '0) begin
            state_d = S_READOUT;
          end else begin
            state_d = S_POST;
            post_d  = POST_M1 - 1'b1;
          end
        end
      end
      S_POST: begin
        we = axiiv;
        if (axiiv) begin
          if (post_q == '0) state_d = S_READOUT;
          else              post_d  = post_q - 1'b1;
        end
      end
      S_READOUT: begin
        if (advance) begin
          if (axiov_q && axiol_q) begin
            // Final beat is being accepted this cycle.
            axiov_d    = 1'b0;
            axiol_d    = 1'b0;
            done_d     = 1'b1;
            state_d    = auto_rearm ? S_FILL : S_IDLE;
            fill_entry = auto_rearm;
          end else begin
            load    = 1'b1;
            axiov_d = 1'b1;
            axiol_d = (rcnt_q == LAST_IDX);
            rp_d    = (rp_q == LAST_IDX) ? '0 : rp_q + 1'b1;
            rcnt_d  = rcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (we) wp_d = (wp_q == LAST_IDX) ? '0 : wp_q + 1'b1;
    if (fill_entry) begin
      wp_d   = '0;
      fill_d = '0;
    end
    // The final write pointer is the oldest retained sample.
    if (state_d == S_READOUT && state_q != S_READOUT) begin
      rp_d   = wp_d;
      rcnt_d = '0;
    end

    dropped_d = fill_entry ? 1'b0
              : (dropped_q | (axiiv && (state_q == S_IDLE || state_q == S_READOUT)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      fill_q    <= '0;
      post_q    <= '0;
      rp_q      <= '0;
      rcnt_q    <= '0;
      axiov_q   <= 1'b0;
      axiol_q   <= 1'b0;
      axiod_q   <= '0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      fill_q    <= fill_d;
      post_q    <= post_d;
      rp_q      <= rp_d;
      rcnt_q    <= rcnt_d;
      axiov_q   <= axiov_d;
      axiol_q   <= axiol_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      if (load) axiod_q <= mem[rp_q];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wp_q] <= axiid;
  end

  assign axiov   = axiov_q;
  assign axiod   = axiod_q;
  assign axiol   = axiol_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Testbench for capture_sequencer.
// DUT A: 2 x 4-bit channels, CAPTURE_LENGTH=16, PRETRIGGER_LENGTH=4.
// DUT B: 1 x 8-bit channel, CAPTURE_LENGTH=1000, PRETRIGGER_LENGTH=0.
// The expected window is the last PRE pre-trigger samples followed by the first
// CAP-PRE samples at or after the trigger, taken from the lists the bench drove.
module tb_capture_sequencer;

  localparam int CAP_A = 16;
  localparam int PRE_A = 4;
  localparam int CAP_B = 1000;

  logic clk, rst;
  logic arm_a, auto_a, trig_a, iv_a, ir_a, ov_a, ol_a, busy_a, done_a, drop_a;
  logic [7:0] id_a, od_a;
  logic arm_b, auto_b, trig_b, iv_b, ir_b, ov_b, ol_b, busy_b, done_b, drop_b;
  logic [7:0] id_b, od_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rmode = 0;

  logic [7:0] got_a_d[$];
  logic       got_a_l[$];
  logic [7:0] got_b_d[$];
  logic       got_b_l[$];
  int         got_b_c[$];
  int done_cnt_a = 0, done_err_a = 0, stall_err_a = 0, last_x_a = 0;
  int done_cnt_b = 0, done_err_b = 0, last_x_b = 0;
  logic st_a = 1'b0;
  logic [7:0] st_d_a = '0;
  logic st_l_a = 1'b0;

  logic [7:0] pre_q[$], post_q[$], exp_q[$];

  capture_sequencer #(
    .SAMPLE_DATA_WIDTH(4), .NUM_CHANNELS(2), .CAPTURE_LENGTH(CAP_A), .PRETRIGGER_LENGTH(PRE_A)
  ) dut_a (
    .clk(clk), .rst(rst), .arm(arm_a), .auto_rearm(auto_a), .trigger(trig_a),
    .axiiv(iv_a), .axiid(id_a), .axior(ir_a), .axiov(ov_a), .axiod(od_a), .axiol(ol_a),
    .busy(busy_a), .done(done_a), .dropped(drop_a)
  );

  capture_sequencer #(
    .SAMPLE_DATA_WIDTH(8), .NUM_CHANNELS(1), .CAPTURE_LENGTH(CAP_B), .PRETRIGGER_LENGTH(0)
  ) dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .auto_rearm(auto_b), .trigger(trig_b),
    .axiiv(iv_b), .axiid(id_b), .axior(ir_b), .axiov(ov_b), .axiod(od_b), .axiol(ol_b),
    .busy(busy_b), .done(done_b), .dropped(drop_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready for DUT A: 0 = always ready, 1 = toggling, 2 = random.
  initial begin
    ir_a = 1'b1;
    ir_b = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       ir_a = 1'b1;
        1:       ir_a = !ir_a;
        default: ir_a = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (ov_a && ir_a) begin
      got_a_d.push_back(od_a);
      got_a_l.push_back(ol_a);
      last_x_a = cyc;
    end
    if (st_a && (ov_a !== 1'b1 || od_a !== st_d_a || ol_a !== st_l_a)) stall_err_a++;
    st_a = ov_a && !ir_a;
    st_d_a = od_a;
    st_l_a = ol_a;
    if (done_a) begin
      done_cnt_a++;
      if (cyc != last_x_a + 1) done_err_a++;
    end
    if (ov_b && ir_b) begin
      got_b_d.push_back(od_b);
      got_b_l.push_back(ol_b);
      got_b_c.push_back(cyc);
      last_x_b = cyc;
    end
    if (done_b) begin
      done_cnt_b++;
      if (cyc != last_x_b + 1) done_err_b++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic samp_a(input logic [7:0] d, input logic t, input bit post);
    iv_a = 1'b1; id_a = d; trig_a = t;
    step();
    iv_a = 1'b0; trig_a = 1'b0;
    if (post) post_q.push_back(d);
    else      pre_q.push_back(d);
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One full capture on DUT A, checked against the window built from the driven samples.
  task automatic cap_a(input string nm, input bit do_arm, input bit rnd, input int npre,
                       input int early_at, input bit coin, input int ndrop, input bit rearm);
    int base, dbase, k, n, npost;
    logic [7:0] v;
    pre_q.delete(); post_q.delete(); exp_q.delete();
    base  = got_a_d.size();
    dbase = done_cnt_a;
    auto_a = rearm;
    if (do_arm) begin
      arm_a = 1'b1; step(); arm_a = 1'b0;
      chk({nm, "_busy_rise"}, 32'(busy_a), 32'd1);
    end
    for (int i = 0; i < npre; i++) begin
      if (i == early_at) begin trig_a = 1'b1; step(); trig_a = 1'b0; end
      v = rnd ? 8'($urandom) : 8'(i);
      samp_a(v, 1'b0, 1'b0);
      if (rnd) idle_a(int'($urandom_range(0, 2)));
    end
    if (coin) samp_a(rnd ? 8'($urandom) : 8'd20, 1'b1, 1'b1);
    else begin trig_a = 1'b1; step(); trig_a = 1'b0; end
    npost = CAP_A - PRE_A - (coin ? 1 : 0);
    for (int i = 0; i < npost; i++) begin
      v = rnd ? 8'($urandom) : 8'(100 + i);
      samp_a(v, 1'b0, 1'b1);
      if (rnd && i != npost - 1) idle_a(int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < ndrop; i++) begin
      iv_a = 1'b1; id_a = 8'hEE; step(); iv_a = 1'b0;
    end
    chk({nm, "_dropped_mid"}, 32'(drop_a), 32'(ndrop > 0));
    k = 0;
    while (done_a !== 1'b1 && k < 400) begin step(); k++; end
    chk({nm, "_done_seen"}, 32'(done_a), 32'd1);
    chk({nm, "_busy_at_done"}, 32'(busy_a), 32'(rearm));
    chk({nm, "_dropped_at_done"}, 32'(drop_a), 32'(ndrop > 0 && !rearm));
    step();
    chk({nm, "_done_count"}, 32'(done_cnt_a - dbase), 32'd1);
    for (int i = pre_q.size() - PRE_A; i < pre_q.size(); i++) exp_q.push_back(pre_q[i]);
    for (int i = 0; i < CAP_A - PRE_A; i++) exp_q.push_back(post_q[i]);
    n = got_a_d.size() - base;
    chk({nm, "_beats"}, 32'(n), 32'(CAP_A));
    for (int i = 0; i < CAP_A && i < n; i++) begin
      chk($sformatf("%s_beat%0d", nm, i), 32'(got_a_d[base + i]), 32'(exp_q[i]));
      chk($sformatf("%s_last%0d", nm, i), 32'(got_a_l[base + i]), 32'(i == CAP_A - 1));
    end
  endtask

  initial begin
    int k, n, mism, ent;
    rst = 1'b1;
    arm_a = 0; auto_a = 0; trig_a = 0; iv_a = 0; id_a = '0;
    arm_b = 0; auto_b = 0; trig_b = 0; iv_b = 0; id_b = '0;
    step(); step();
    chk("rst_A_axiov", 32'(ov_a), 0);
    chk("rst_A_axiod", 32'(od_a), 0);
    chk("rst_A_flags", {27'd0, ol_a, busy_a, done_a, drop_a, 1'b0}, 0);
    chk("rst_B_outs", {14'd0, ov_b, ol_b, busy_b, done_b, drop_b, 5'd0, od_b}, 0);
    rst = 1'b0;
    step();

    // Basic capture, trigger coincident with sample 20, then backpressure.
    rmode = 0;
    cap_a("basic", 1, 0, 10, -1, 0, 0, 0);
    cap_a("coin", 1, 0, 7, 2, 1, 0, 0);
    chk("coin_beat5_is_20", 32'(got_a_d[got_a_d.size() - CAP_A + 4]), 32'd20);
    rmode = 1;
    cap_a("bp", 1, 0, 10, -1, 0, 0, 0);
    rmode = 0;

    // Asynchronous reset in the middle of POST.
    arm_a = 1'b1; step(); arm_a = 1'b0;
    for (int i = 0; i < 4; i++) samp_a(8'(i), 1'b0, 1'b0);
    trig_a = 1'b1; step(); trig_a = 1'b0;
    for (int i = 0; i < 3; i++) samp_a(8'(50 + i), 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_axiov", 32'(ov_a), 0);
    chk("midrst_busy", 32'(busy_a), 0);
    chk("midrst_rest", {22'd0, ol_a, done_a, od_a, drop_a, 1'b0}, 0);
    #2 rst = 1'b0;
    step();
    iv_a = 1'b1; id_a = 8'h11; step(); iv_a = 1'b0;
    chk("postrst_idle_drop", 32'(drop_a), 32'd1);
    cap_a("postrst", 1, 0, 10, -1, 0, 0, 0);

    // Auto-rearm with samples dropped during readout, then a second capture.
    cap_a("ar1", 1, 0, 6, -1, 0, 3, 1);
    cap_a("ar2", 0, 1, 5, -1, 0, 0, 0);

    // Randomized captures with random ready.
    rmode = 2;
    for (int r = 0; r < 5; r++) begin
      cap_a($sformatf("rnd%0d", r), 1, 1, int'($urandom_range(4, 10)),
            int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), 0);
    end
    rmode = 0;

    // DUT B: no pre-trigger history, non-power-of-2 length.
    arm_b = 1'b1; step(); arm_b = 1'b0;
    step();
    trig_b = 1'b1; step(); trig_b = 1'b0;
    for (int i = 0; i < CAP_B; i++) begin
      iv_b = 1'b1; id_b = 8'(i); step();
    end
    iv_b = 1'b0;
    ent = cyc;
    k = 0;
    while (done_b !== 1'b1 && k < 1200) begin step(); k++; end
    chk("B_done_seen", 32'(done_b), 32'd1);
    chk("B_busy_at_done", 32'(busy_b), 0);
    step();
    chk("B_done_count", 32'(done_cnt_b), 32'd1);
    n = got_b_d.size();
    chk("B_beats", 32'(n), 32'(CAP_B));
    mism = 0;
    for (int i = 0; i < n && i < CAP_B; i++) begin
      if (got_b_d[i] !== 8'(i % 256) || got_b_l[i] !== 1'(i == CAP_B - 1)) mism++;
    end
    chk("B_window_mismatches", 32'(mism), 0);
    if (n == CAP_B) begin
      chk("B_beat0", 32'(got_b_d[0]), 0);
      chk("B_beat999", 32'(got_b_d[999]), 32'(999 % 256));
      chk("B_first_latency_ok", 32'(got_b_c[0] <= ent + 2), 32'd1);
      chk("B_throughput", 32'(got_b_c[CAP_B - 1] - got_b_c[0]), 32'(CAP_B - 1));
    end

    chk("A_stall_hold_errors", 32'(stall_err_a), 0);
    chk("A_done_timing_errors", 32'(done_err_a), 0);
    chk("B_done_timing_errors", 32'(done_err_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
